histogram_map_param: RTL and testbench

//  Parametrised run-length histogram map stage for ping-pong dataflow pipelines.

---
 rtl/histogram_map_param.sv | 220 ++++++++++++++++++++++
 tb/tb_histogram_map_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_map_param.sv
// histogram_map_param: run-length histogram map stage for ping-pong dataflow pipelines.
// It clears an N_BINS-entry count RAM and then scans N_IN samples from the sample RAM.
// Consecutive equal samples accumulate in a register, so the count RAM is written only
// when the sample value changes, plus once at the end of the run.
// Samples at or above N_BINS are dropped and counted in drop_cnt.
//
// Ports:
//   ap_clk, ap_rst           clock; asynchronous active-high reset
//   ap_start/ap_done/ap_idle/ap_ready/ap_continue   block-level handshake
//   in_r_address0/ce0/q0     sample RAM read port (1-cycle latency)
//   hist_address0/ce0/we0/d0 count RAM write port
//   hist_address1/ce1/q1     count RAM read port (1-cycle latency)
//   drop_cnt                 out-of-range samples in the current or last run
//
// Configuration macro: HISTOGRAM_MAP_SAT_EN
//   defined   -> bin counters saturate at 2^CNT_W-1
//   undefined -> bin counters wrap modulo 2^CNT_W
module histogram_map_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_IN   = 4,
    parameter int unsigned IN_AW  = 2,
    parameter int unsigned N_BINS = 256,
    parameter int unsigned BIN_AW = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [IN_AW-1:0]  in_r_address0,
    output logic              in_r_ce0,
    input  logic [DATA_W-1:0] in_r_q0,
    output logic [BIN_AW-1:0] hist_address0,
    output logic              hist_ce0,
    output logic              hist_we0,
    output logic [CNT_W-1:0]  hist_d0,
    output logic [BIN_AW-1:0] hist_address1,
    output logic              hist_ce1,
    input  logic [CNT_W-1:0]  hist_q1,
    output logic [IN_AW:0]    drop_cnt
);

    localparam int unsigned IDX_W = IN_AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_UPD   = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [BIN_AW-1:0] clr;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  acc;
    logic [DATA_W-1:0] old;
    logic [DATA_W-1:0] val_r;
    logic              old_valid;
    logic              eq;
    logic              done_reg;

    logic              start_acc;
    logic              idx_done;
    logic              val_oor;
    logic              val_eq;

    // Counter increment, saturating or wrapping depending on build
    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] x);
`ifdef HISTOGRAM_MAP_SAT_EN
        return (&x) ? x : x + CNT_W'(1);
`else
        return x + CNT_W'(1);
`endif
    endfunction

    assign start_acc = (state == S_IDLE) && ap_start && !done_reg;
    assign idx_done  = (idx == IDX_W'(N_IN));
    // Range check uses the full sample width before the bin address is truncated
    assign val_oor   = ({1'b0, in_r_q0} >= (DATA_W + 1)'(N_BINS));
    assign val_eq    = old_valid && (in_r_q0 == old);

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and RAM/handshake outputs
    always_comb begin
        state_nxt     = state;
        ap_done       = done_reg;
        ap_ready      = 1'b0;
        ap_idle       = (state == S_IDLE) && !ap_start;
        in_r_address0 = '0;
        in_r_ce0      = 1'b0;
        hist_address0 = '0;
        hist_ce0      = 1'b0;
        hist_we0      = 1'b0;
        hist_d0       = '0;
        hist_address1 = '0;
        hist_ce1      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_acc) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                hist_address0 = clr;
                hist_ce0      = 1'b1;
                hist_we0      = 1'b1;
                if (clr == BIN_AW'(N_BINS - 1)) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (idx_done) begin
                    // Flush the last open run
                    if (old_valid) begin
                        hist_address0 = old[BIN_AW-1:0];
                        hist_ce0      = 1'b1;
                        hist_we0      = 1'b1;
                        hist_d0       = acc;
                    end
                    ap_done   = 1'b1;
                    ap_ready  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    in_r_address0 = idx[IN_AW-1:0];
                    in_r_ce0      = 1'b1;
                    state_nxt     = S_CMP;
                end
            end
            S_CMP: begin
                if (val_oor) begin
                    state_nxt = S_RD;
                end else begin
                    state_nxt = S_UPD;
                    // New value: fetch its count and retire the previous run.
                    // val != old here, so the two ports never hit the same bin.
                    if (!val_eq) begin
                        hist_address1 = in_r_q0[BIN_AW-1:0];
                        hist_ce1      = 1'b1;
                        if (old_valid) begin
                            hist_address0 = old[BIN_AW-1:0];
                            hist_ce0      = 1'b1;
                            hist_we0      = 1'b1;
                            hist_d0       = acc;
                        end
                    end
                end
            end
            S_UPD: begin
                state_nxt = S_RD;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            clr       <= '0;
            idx       <= '0;
            acc       <= '0;
            old       <= '0;
            val_r     <= '0;
            old_valid <= 1'b0;
            eq        <= 1'b0;
            done_reg  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if ((state == S_RD) && idx_done) begin
                done_reg <= !ap_continue;
            end else if (ap_continue) begin
                done_reg <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start_acc) begin
                        clr       <= '0;
                        idx       <= '0;
                        acc       <= '0;
                        old_valid <= 1'b0;
                        drop_cnt  <= '0;
                    end
                end
                S_CLEAR: begin
                    clr <= clr + BIN_AW'(1);
                end
                S_CMP: begin
                    if (val_oor) begin
                        drop_cnt <= drop_cnt + IDX_W'(1);
                        idx      <= idx + IDX_W'(1);
                    end else begin
                        eq    <= val_eq;
                        val_r <= in_r_q0;
                    end
                end
                S_UPD: begin
                    acc       <= inc(eq ? acc : hist_q1);
                    old       <= val_r;
                    old_valid <= 1'b1;
                    idx       <= idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_map_param.sv
// Bench for histogram_map_param: instance 0 uses default parameters, instance 1 uses
// N_BINS=16, BIN_AW=4, CNT_W=2. A reference histogram is computed per run and queued;
// the queue is drained against the count RAM model once ap_done is seen.
module tb_histogram_map_param;

    typedef struct {
        int     inst;
        int     bin;
        longint val;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [2];
    logic        ap_start    [2];
    logic        ap_continue [2];
    logic        ap_done     [2];
    logic        ap_idle     [2];
    logic        ap_ready    [2];
    logic [1:0]  in_addr     [2];
    logic        in_ce0      [2];
    logic [31:0] in_q0       [2];
    logic [7:0]  h_addr0     [2];
    logic [7:0]  h_addr1     [2];
    logic        h_ce0       [2];
    logic        h_we0       [2];
    logic        h_ce1       [2];
    logic [31:0] h_d0        [2];
    logic [31:0] h_q1        [2];
    logic [2:0]  drop        [2];

    logic [3:0]  s_addr0;
    logic [3:0]  s_addr1;
    logic [1:0]  s_d0;
    logic [1:0]  s_q1;

    assign h_addr0[1] = {4'b0, s_addr0};
    assign h_addr1[1] = {4'b0, s_addr1};
    assign h_d0[1]    = {30'b0, s_d0};
    assign s_q1       = h_q1[1][1:0];

    logic [31:0] in_mem   [2][4];
    logic [31:0] hist_mem [2][256];
    int          wr_cnt   [2] = '{0, 0};
    int          collide  [2] = '{0, 0};

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    histogram_map_param u_dut0 (
        .ap_clk        (clk),
        .ap_rst        (rst[0]),
        .ap_start      (ap_start[0]),
        .ap_done       (ap_done[0]),
        .ap_continue   (ap_continue[0]),
        .ap_idle       (ap_idle[0]),
        .ap_ready      (ap_ready[0]),
        .in_r_address0 (in_addr[0]),
        .in_r_ce0      (in_ce0[0]),
        .in_r_q0       (in_q0[0]),
        .hist_address0 (h_addr0[0]),
        .hist_ce0      (h_ce0[0]),
        .hist_we0      (h_we0[0]),
        .hist_d0       (h_d0[0]),
        .hist_address1 (h_addr1[0]),
        .hist_ce1      (h_ce1[0]),
        .hist_q1       (h_q1[0]),
        .drop_cnt      (drop[0])
    );

    histogram_map_param #(
        .N_BINS (16),
        .BIN_AW (4),
        .CNT_W  (2)
    ) u_dut1 (
        .ap_clk        (clk),
        .ap_rst        (rst[1]),
        .ap_start      (ap_start[1]),
        .ap_done       (ap_done[1]),
        .ap_continue   (ap_continue[1]),
        .ap_idle       (ap_idle[1]),
        .ap_ready      (ap_ready[1]),
        .in_r_address0 (in_addr[1]),
        .in_r_ce0      (in_ce0[1]),
        .in_r_q0       (in_q0[1]),
        .hist_address0 (s_addr0),
        .hist_ce0      (h_ce0[1]),
        .hist_we0      (h_we0[1]),
        .hist_d0       (s_d0),
        .hist_address1 (s_addr1),
        .hist_ce1      (h_ce1[1]),
        .hist_q1       (s_q1),
        .drop_cnt      (drop[1])
    );

    // Sample ROM and count RAM models, plus write and same-bin collision tallies
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (in_ce0[g]) in_q0[g] <= in_mem[g][in_addr[g]];
            if (h_ce1[g]) h_q1[g] <= hist_mem[g][h_addr1[g]];
            if (h_ce0[g] && h_we0[g]) begin
                hist_mem[g][h_addr0[g]] <= h_d0[g];
                wr_cnt[g] <= wr_cnt[g] + 1;
                if (h_ce1[g] && (h_addr0[g] == h_addr1[g])) collide[g] <= collide[g] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One complete run: load samples, queue the reference histogram, start, wait for done, compare
    task automatic run_test(input int inst, input int s0, input int s1, input int s2, input int s3,
                            input int exp_drop, input int exp_lat, input bit hold);
        int     smp [4];
        int     cnt [256];
        int     nb;
        longint maxv;
        longint e;
        int     runs;
        int     last;
        bit     have;
        int     wr0;
        int     col0;
        int     lat;
        sb_t    it;
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        nb   = (inst == 0) ? 256 : 16;
        maxv = (inst == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd3;
        for (int b = 0; b < 256; b++) cnt[b] = 0;
        runs = 0; last = 0; have = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_mem[inst][i] = 32'(smp[i]);
            if (smp[i] < nb) begin
                cnt[smp[i]]++;
                if (!have || smp[i] != last) runs++;
                last = smp[i];
                have = 1'b1;
            end
        end
        for (int b = 0; b < nb; b++) begin
`ifdef HISTOGRAM_MAP_SAT_EN
            e = (longint'(cnt[b]) > maxv) ? maxv : longint'(cnt[b]);
`else
            e = longint'(cnt[b]) % (maxv + 1);
`endif
            it.inst = inst; it.bin = b; it.val = e;
            sb_q.push_back(it);
        end
        wr0  = wr_cnt[inst];
        col0 = collide[inst];
        @(negedge clk);
        ap_start[inst] = 1'b1;
        @(posedge clk);
        #1 ap_start[inst] = 1'b0;
        lat = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (ap_done[inst]) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            check_eq("done_timeout", 0, 1);
            sb_q.delete();
        end else begin
            check_eq("ap_ready_at_done", longint'(ap_ready[inst]), 1);
            if (exp_lat > 0) check_eq("latency", lat, exp_lat);
            @(posedge clk);
            #1;
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                check_eq($sformatf("hist[%0d][%0d]", it.inst, it.bin),
                         longint'(hist_mem[it.inst][it.bin]), it.val);
            end
        end
        check_eq("drop_cnt", longint'(drop[inst]), exp_drop);
        check_eq("ram_writes", wr_cnt[inst] - wr0, nb + runs);
        check_eq("port_collide", collide[inst] - col0, 0);
        if (!hold) begin
            @(negedge clk);
            ap_continue[inst] = 1'b1;
            @(negedge clk);
            ap_continue[inst] = 1'b0;
            check_eq("done_cleared", longint'(ap_done[inst]), 0);
            check_eq("drop_hold", longint'(drop[inst]), exp_drop);
        end
    endtask

    initial begin
        int w;
        for (int g = 0; g < 2; g++) begin
            rst[g]         = 1'b1;
            ap_start[g]    = 1'b0;
            ap_continue[g] = 1'b0;
        end
        #1;
        check_eq("rst_idle", longint'(ap_idle[0]), 1);
        check_eq("rst_done", longint'(ap_done[0]), 0);
        check_eq("rst_drop", longint'(drop[0]), 0);
        check_eq("rst_hist_ce0", longint'(h_ce0[0]), 0);
        check_eq("rst_in_ce0", longint'(in_ce0[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Basic run and re-read path
        run_test(0, 3, 3, 3, 7, 0, 269, 1'b0);
        run_test(0, 5, 9, 5, 9, 0, 269, 1'b0);

        // Range checking on the small instance
        run_test(1, 20, 2, 99, 2, 2, 0, 1'b0);
        run_test(1, 16, 17, 18, 19, 4, 0, 1'b0);

        // Narrow counter: saturate or wrap
        run_test(1, 1, 1, 1, 1, 0, 29, 1'b0);

        // Done held without ap_continue; ap_start ignored meanwhile
        run_test(0, 5, 9, 5, 9, 0, 269, 1'b1);
        w = wr_cnt[0];
        ap_start[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("done_held", longint'(ap_done[0]), 1);
        check_eq("start_ignored", wr_cnt[0] - w, 0);
        ap_start[0] = 1'b0;
        @(negedge clk);
        ap_continue[0] = 1'b1;
        @(negedge clk);
        ap_continue[0] = 1'b0;
        check_eq("done_after_cont", longint'(ap_done[0]), 0);
        check_eq("idle_after_cont", longint'(ap_idle[0]), 1);
        run_test(0, 3, 3, 3, 7, 0, 269, 1'b0);

        // Asynchronous reset in the middle of the clear phase
        run_test(0, 1, 2, 3, 4, 0, 269, 1'b0);
        @(negedge clk);
        ap_start[0] = 1'b1;
        @(posedge clk);
        #1 ap_start[0] = 1'b0;
        repeat (101) @(negedge clk);
        check_eq("clr_addr_pre_rst", longint'(h_addr0[0]), 100);
        rst[0] = 1'b1;
        #1;
        check_eq("arst_hist_ce0", longint'(h_ce0[0]), 0);
        check_eq("arst_hist_we0", longint'(h_we0[0]), 0);
        check_eq("arst_hist_addr0", longint'(h_addr0[0]), 0);
        check_eq("arst_idle", longint'(ap_idle[0]), 1);
        check_eq("arst_done", longint'(ap_done[0]), 0);
        @(negedge clk);
        rst[0] = 1'b0;
        run_test(0, 3, 3, 3, 7, 0, 269, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
